kdw_loader: RTL and testbench
=============================

KDW_LOADER -- requirements
Module: kdw_loader

Interface
REQ-001 The block SHALL have a parameter N_ELEM, default KDW_N_ELEM (ram_pkg), giving the depth of the depthwise-kernel RAM it fills.
REQ-002 The block SHALL have a parameter DATA_W, default WG_W (ram_pkg), giving the weight word width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a 1-cycle load request.
REQ-006 The block SHALL have port base, input, $clog2(N_ELEM) bits: the first RAM address, sampled with start.
REQ-007 The block SHALL have port count, input, $clog2(N_ELEM+1) bits: the number of words to load, sampled with start.
REQ-008 The block SHALL have port abort, input, 1 bit: cancels a load in progress.
REQ-009 The block SHALL have port in_valid, input, 1 bit: the DMA weight stream is valid.
REQ-010 The block SHALL have port in_data, input, DATA_W bits: the DMA weight word.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-012 The block SHALL have port ram_addr, output, $clog2(N_ELEM) bits: the address to RAM_KDW.
REQ-013 The block SHALL have port ram_data, output, DATA_W bits: the write data to RAM_KDW.
REQ-014 The block SHALL have port ram_write, output, 1 bit: the write strobe to RAM_KDW.
REQ-015 The block SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: a 1-cycle completion pulse.
REQ-017 The block SHALL have port err, output, 1 bit: sticky flag for an illegal count, cleared by the next accepted start.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, LOAD and FIN.
REQ-019 In IDLE, start=1 SHALL latch base into the address pointer and count into the remaining counter, then move as follows: count=0 to FIN; count>N_ELEM to FIN with err set; otherwise to LOAD.
REQ-020 start SHALL be ignored in any state other than IDLE.
REQ-021 in_ready SHALL be combinational and equal (state==LOAD) && !abort.
REQ-022 A transfer SHALL occur on a cycle with in_valid && in_ready.
REQ-023 Each transfer SHALL register, on the next cycle: ram_write=1, ram_addr=pointer, ram_data=in_data (1-cycle latency, one write per transfer).
REQ-024 Each transfer SHALL decrement the remaining counter.
REQ-025 Each transfer SHALL advance the pointer by 1, wrapping from N_ELEM-1 to 0 (this rule also covers N_ELEM that is not a power of two).
REQ-026 ram_write SHALL be 0 on every cycle not following a transfer; ram_addr and ram_data SHALL hold their last values.
REQ-027 A transfer that leaves remaining=0 SHALL move the FSM to FIN.
REQ-028 FIN SHALL last exactly 1 cycle with done=1, so that done coincides with the last ram_write, and SHALL then return to IDLE.
REQ-029 in_valid=0 in LOAD SHALL stall the load with no write and no counter or pointer change.
REQ-030 abort=1 in LOAD SHALL move the FSM to IDLE on the next edge, with no transfer that cycle, no done and err unchanged.
REQ-031 abort SHALL be ignored in IDLE and in FIN.
REQ-032 busy SHALL equal (state!=IDLE).
REQ-033 A new start SHALL be accepted only on the cycle after FIN, once the FSM is in IDLE.

Reset
REQ-034 rst_n=0 SHALL, asynchronously, force state=IDLE, pointer=0, remaining=0, ram_write=0, ram_addr=0, ram_data=0, done=0, err=0 and busy=0, and in_ready SHALL go to 0.
REQ-035 Reset asserted mid-load SHALL abandon the load with no further writes.
REQ-036 After rst_n rises, the first start SHALL be honoured on the first rising edge.

Verification
REQ-037 (with N_ELEM=16) start, base=3, count=4, in_valid held high with data A,B,C,D -> writes to addresses 3,4,5,6 on 4 consecutive cycles, each 1 cycle after its accept; done on the cycle of the write to address 6; busy for 5 cycles.
REQ-038 base=14, count=4 -> writes to addresses 14,15,0,1.
REQ-039 count=0 -> no ram_write; done 1 cycle after start; err=0.
REQ-040 count=17 -> err=1, no writes, done pulse; a following start with count=2 clears err.
REQ-041 in_valid toggling 1,0,0,1,1 during a count=3 load -> exactly 3 writes at consecutive addresses; the stall cycles leave the pointer unchanged.
REQ-042 abort after 2 of 5 accepts -> 2 writes, busy=0 the next cycle, no done; likewise rst_n pulsed low mid-load -> all outputs at reset values immediately.

Source files
------------

// File: rtl/kdw_loader.sv
`default_nettype none
// ============================================================================
// Module      : kdw_loader (with ram_pkg)
// Description : Streams depthwise-kernel weights from a DMA valid/ready
//               stream into RAM_KDW, starting at a given base address and
//               wrapping at the end of the RAM.
// Revision    : 1.0 - initial release
// ============================================================================

package ram_pkg;
  localparam int KDW_N_ELEM = 16;
  localparam int WG_W       = 8;
endpackage

module kdw_loader #(
  parameter int N_ELEM = ram_pkg::KDW_N_ELEM,
  parameter int DATA_W = ram_pkg::WG_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(N_ELEM)-1:0]   base,
  input  logic [$clog2(N_ELEM+1)-1:0] count,
  input  logic                        abort,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic [$clog2(N_ELEM)-1:0]   ram_addr,
  output logic [DATA_W-1:0]           ram_data,
  output logic                        ram_write,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int AW = $clog2(N_ELEM);
  localparam int CW = $clog2(N_ELEM + 1);

  localparam logic [AW-1:0] C_LAST_ADDR = AW'(N_ELEM - 1);
  localparam logic [AW-1:0] C_PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] C_N_ELEM    = CW'(N_ELEM);
  localparam logic [CW-1:0] C_CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_ptr;
  logic [CW-1:0]   r_remaining;
  logic            r_err;
  logic            w_xfer;
  logic            w_accept;
  logic            w_bad_count;

  // A start is only meaningful while idle; later starts are dropped.
  assign w_accept    = (r_state == IDLE) && start;
  assign w_bad_count = (count > C_N_ELEM);

  assign in_ready = (r_state == LOAD) && !abort;
  assign w_xfer   = in_ready && in_valid;
  assign busy     = (r_state != IDLE);
  // FIN is entered on the same edge that registers the final write.
  assign done     = (r_state == FIN);
  assign err      = r_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: zero or oversize counts skip straight to FIN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if ((count == '0) || w_bad_count) begin
            w_next = FIN;
          end else begin
            w_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_xfer && (r_remaining == C_CNT_ONE)) begin
          w_next = FIN;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pointer, remaining count, error flag and the registered RAM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
      ram_write   <= 1'b0;
      ram_addr    <= '0;
      ram_data    <= '0;
    end else begin
      if (w_accept) begin
        r_ptr       <= base;
        r_remaining <= count;
        r_err       <= w_bad_count;
      end else if (w_xfer) begin
        r_remaining <= r_remaining - C_CNT_ONE;
        // Explicit wrap so non-power-of-two depths stay in range.
        r_ptr       <= (r_ptr == C_LAST_ADDR) ? '0 : (r_ptr + C_PTR_ONE);
      end
      ram_write <= w_xfer;
      if (w_xfer) begin
        ram_addr <= r_ptr;
        ram_data <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kdw_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_kdw_loader
// Description : Self-checking bench for kdw_loader: directed table of loads,
//               randomized loads against a transaction-level model, and a
//               reset-during-load sequence.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_kdw_loader;

  localparam int N  = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    base;
  logic [4:0]    count;
  logic          abort;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [3:0]    ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_write;
  logic          busy;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;

  logic [3:0]    last_addr;
  logic [DW-1:0] last_data;

  kdw_loader #(.N_ELEM(N), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .count    (count),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_write(ram_write),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ram_write"}, ram_write, 0);
    chk({tag, " ram_addr"},  ram_addr,  0);
    chk({tag, " ram_data"},  ram_data,  0);
    chk({tag, " busy"},      busy,      0);
    chk({tag, " done"},      done,      0);
    chk({tag, " err"},       err,       0);
    chk({tag, " in_ready"},  in_ready,  0);
  endtask

  // One load transaction. Expectations come from the load's rules: word k
  // lands at (b+k) mod N one cycle after it is accepted; zero/oversize counts
  // give a lone done pulse; abort ends the load with no done.
  task automatic run_load(input int b, input int c, input logic [7:0] vp, input bit rndv,
                          input int ab_at, output int n_wr, output int last_a,
                          output int n_done, output int n_busy, output int err_o);
    bit            legal, loading, fin_now, xfer, v, ab, exp_err;
    int            acc, cyc, exp_a;
    logic [DW-1:0] sent[$];
    n_wr = 0; last_a = -1; n_done = 0; n_busy = 0; acc = 0; cyc = 0; xfer = 0;
    legal   = (c != 0) && (c <= N);
    exp_err = (c > N);
    start    = 1'b1;
    base     = 4'(b);
    count    = 5'(c);
    abort    = 1'($urandom_range(0, 1));
    in_valid = 1'($urandom_range(0, 1));
    in_data  = DW'($urandom);
    @(posedge clk); #1;
    loading = legal;
    fin_now = !legal;
    forever begin
      start = 1'b0;
      if (xfer) begin
        exp_a = (b + n_wr) % N;
        chk("wr strobe", ram_write, 1);
        chk("wr addr",   ram_addr,  exp_a);
        chk("wr data",   ram_data,  sent[n_wr]);
        last_addr = 4'(exp_a);
        last_data = sent[n_wr];
        last_a    = exp_a;
        n_wr++;
      end else begin
        chk("no-write strobe", ram_write, 0);
        chk("hold addr",       ram_addr,  last_addr);
        chk("hold data",       ram_data,  last_data);
      end
      chk("busy", busy, loading || fin_now);
      chk("done", done, fin_now);
      chk("err",  err,  exp_err);
      if (done) n_done++;
      if (!(loading || fin_now)) break;
      n_busy++;
      if (cyc >= 200) begin
        chk("load timeout", 1, 0);
        break;
      end
      ab = loading && (ab_at >= 0) && (acc == ab_at);
      if (fin_now) ab = 1'($urandom_range(0, 1));
      v = rndv ? ($urandom_range(0, 9) < 7) : ((cyc < 8) ? vp[cyc] : 1'b1);
      in_valid = v;
      in_data  = DW'($urandom);
      abort    = ab;
      start    = 1'($urandom_range(0, 1));
      base     = 4'($urandom);
      count    = 5'($urandom);
      #1;
      chk("in_ready", in_ready, loading && !ab);
      xfer = loading && v && !ab;
      if (xfer) sent.push_back(in_data);
      if (fin_now) begin
        fin_now = 1'b0;
      end else if (ab) begin
        loading = 1'b0;
      end else if (xfer) begin
        acc++;
        if (acc == c) begin
          loading = 1'b0;
          fin_now = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    err_o = int'(err);
  endtask

  typedef struct {
    int         b;
    int         c;
    logic [7:0] vp;
    int         ab;
    int         wr;
    int         last;
    int         dn;
    int         bsy;
    int         er;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n_wr, last_a, n_done, n_busy, err_o;
    int b, c, ab_at, e_wr, e_last;
    bit lg, abd;

    vecs[0] = '{3,  4,  8'hFF, -1, 4,  6,  1, 5,  0};  // basic load
    vecs[1] = '{14, 4,  8'hFF, -1, 4,  1,  1, 5,  0};  // wrap at top
    vecs[2] = '{0,  0,  8'hFF, -1, 0,  -1, 1, 1,  0};  // empty load
    vecs[3] = '{2,  17, 8'hFF, -1, 0,  -1, 1, 1,  1};  // oversize count
    vecs[4] = '{7,  2,  8'hFF, -1, 2,  8,  1, 3,  0};  // clears err
    vecs[5] = '{9,  3,  8'h19, -1, 3,  11, 1, 6,  0};  // valid 1,0,0,1,1
    vecs[6] = '{4,  5,  8'hFF, 2,  2,  5,  0, 3,  0};  // abort after 2
    vecs[7] = '{15, 16, 8'hFF, -1, 16, 14, 1, 17, 0};  // full RAM
    vecs[8] = '{15, 1,  8'hFF, -1, 1,  15, 1, 2,  0};  // single word

    rst_n = 1'b0; start = 1'b0; base = '0; count = '0;
    abort = 1'b0; in_valid = 1'b0; in_data = '0;
    last_addr = '0; last_data = '0;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_load(vecs[i].b, vecs[i].c, vecs[i].vp, 1'b0, vecs[i].ab,
               n_wr, last_a, n_done, n_busy, err_o);
      chk($sformatf("vec%0d writes", i),    n_wr,   vecs[i].wr);
      chk($sformatf("vec%0d last addr", i), last_a, vecs[i].last);
      chk($sformatf("vec%0d done", i),      n_done, vecs[i].dn);
      chk($sformatf("vec%0d busy cyc", i),  n_busy, vecs[i].bsy);
      chk($sformatf("vec%0d err", i),       err_o,  vecs[i].er);
    end

    for (int t = 0; t < 40; t++) begin
      b     = $urandom_range(0, N - 1);
      c     = $urandom_range(0, N + 2);
      ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, c) : -1;
      lg    = (c != 0) && (c <= N);
      abd   = lg && (ab_at >= 0) && (ab_at < c);
      e_wr  = !lg ? 0 : (abd ? ab_at : c);
      e_last = (e_wr == 0) ? -1 : ((b + e_wr - 1) % N);
      run_load(b, c, 8'h00, 1'b1, ab_at, n_wr, last_a, n_done, n_busy, err_o);
      chk("rnd writes",    n_wr,   e_wr);
      chk("rnd last addr", last_a, e_last);
      chk("rnd done",      n_done, abd ? 0 : 1);
      chk("rnd err",       err_o,  (c > N) ? 1 : 0);
    end

    // Reset in the middle of a load: outputs clear at once, nothing written after.
    start = 1'b1; base = 4'd5; count = 5'd6; in_valid = 1'b1; in_data = 8'hA5; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid-load reset");
    @(posedge clk); #1;
    chk("reset hold strobe", ram_write, 0);
    chk("reset hold busy",   busy,      0);
    #3 rst_n = 1'b1;
    last_addr = '0; last_data = '0;
    @(posedge clk); #1;
    chk("post-reset idle strobe", ram_write, 0);
    chk("post-reset idle busy",   busy,      0);
    in_valid = 1'b0;
    // First start after reset is taken on the first edge.
    run_load(10, 3, 8'hFF, 1'b0, -1, n_wr, last_a, n_done, n_busy, err_o);
    chk("post-reset writes", n_wr,   3);
    chk("post-reset last",   last_a, 12);
    chk("post-reset busy",   n_busy, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
